// File: rtl/uart_reg_responder.sv
// Host-frame responder: turns UART 'W'/'R' frames into register-bus accesses and answers with ACK, read data or NAK.
// Optional trailing XOR checksum and complemented second response byte: define UART_RESP_CHECKSUM_EN.
module uart_reg_responder #(
    parameter int         TIMEOUT_CYC = 8680,
    parameter logic [7:0] ACK_BYTE    = 8'h06,
    parameter logic [7:0] NAK_BYTE    = 8'h15
) (
    input  logic       clk_50m,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_rdy,
    output logic       rx_rdy_clr,
    output logic [7:0] tx_data,
    output logic       tx_wr_en,
    input  logic       tx_busy,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    output logic       reg_re,
    input  logic [7:0] reg_rdata
);
    localparam int               TMR_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);
    localparam logic [7:0]       CMD_WR   = 8'h57;
    localparam logic [7:0]       CMD_RD   = 8'h52;

`ifdef UART_RESP_CHECKSUM_EN
    typedef enum logic [2:0] {
        IDLE, GET_ADDR, GET_DATA, GET_CHK, EXEC, READ_WAIT, SEND, SEND_WAIT
    } state_t;
    localparam state_t LAST_NEXT = GET_CHK;
    localparam bit     DUAL_RESP = 1'b1;
`else
    typedef enum logic [2:0] {
        IDLE, GET_ADDR, GET_DATA, EXEC, READ_WAIT, SEND, SEND_WAIT
    } state_t;
    localparam state_t LAST_NEXT = EXEC;
    localparam bit     DUAL_RESP = 1'b0;
`endif

    state_t           state, state_n;
    logic [TMR_W-1:0] timer, timer_n;
    logic             rx_rdy_clr_n, tx_wr_en_n, reg_we_n, reg_re_n;
    logic [7:0]       tx_data_n, reg_addr_n, reg_wdata_n;
    logic             is_wr, is_wr_n;
    logic [7:0]       resp, resp_n;
    logic             resp_pend, pend_n;
    logic             sw_first, sw_first_n;
    logic             accept, in_get;
`ifdef UART_RESP_CHECKSUM_EN
    logic [7:0]       chk_acc, chk_acc_n;
    logic             chk_ok, chk_ok_n;
`endif

    always_comb begin
        state_n      = state;
        timer_n      = '0;
        rx_rdy_clr_n = 1'b0;
        tx_wr_en_n   = 1'b0;
        reg_we_n     = 1'b0;
        reg_re_n     = 1'b0;
        tx_data_n    = tx_data;
        reg_addr_n   = reg_addr;
        reg_wdata_n  = reg_wdata;
        is_wr_n      = is_wr;
        resp_n       = resp;
        pend_n       = resp_pend;
        sw_first_n   = 1'b0;
`ifdef UART_RESP_CHECKSUM_EN
        chk_acc_n    = chk_acc;
        chk_ok_n     = chk_ok;
`endif
        // The clear pulse is still in flight while rx_rdy is high, so that cycle never accepts.
        accept       = rx_rdy && !rx_rdy_clr;
        in_get       = 1'b0;

        case (state)
            IDLE: begin
                if (accept) begin
                    rx_rdy_clr_n = 1'b1;
`ifdef UART_RESP_CHECKSUM_EN
                    chk_acc_n    = rx_data;
`endif
                    if (rx_data == CMD_WR || rx_data == CMD_RD) begin
                        is_wr_n = (rx_data == CMD_WR);
                        state_n = GET_ADDR;
                    end else begin
                        resp_n  = NAK_BYTE;
                        pend_n  = DUAL_RESP;
                        state_n = SEND;
                    end
                end
            end
            GET_ADDR: begin
                in_get = 1'b1;
                if (accept) begin
                    rx_rdy_clr_n = 1'b1;
                    reg_addr_n   = rx_data;
`ifdef UART_RESP_CHECKSUM_EN
                    chk_acc_n    = chk_acc ^ rx_data;
`endif
                    state_n      = is_wr ? GET_DATA : LAST_NEXT;
                end
            end
            GET_DATA: begin
                in_get = 1'b1;
                if (accept) begin
                    rx_rdy_clr_n = 1'b1;
                    reg_wdata_n  = rx_data;
`ifdef UART_RESP_CHECKSUM_EN
                    chk_acc_n    = chk_acc ^ rx_data;
`endif
                    state_n      = LAST_NEXT;
                end
            end
`ifdef UART_RESP_CHECKSUM_EN
            GET_CHK: begin
                in_get = 1'b1;
                if (accept) begin
                    rx_rdy_clr_n = 1'b1;
                    chk_ok_n     = (rx_data == chk_acc);
                    state_n      = EXEC;
                end
            end
`endif
            EXEC: begin
`ifdef UART_RESP_CHECKSUM_EN
                if (!chk_ok) begin
                    resp_n  = NAK_BYTE;
                    pend_n  = 1'b1;
                    state_n = SEND;
                end else
`endif
                if (is_wr) begin
                    reg_we_n = 1'b1;
                    resp_n   = ACK_BYTE;
                    pend_n   = DUAL_RESP;
                    state_n  = SEND;
                end else begin
                    reg_re_n = 1'b1;
                    state_n  = READ_WAIT;
                end
            end
            READ_WAIT: begin
                resp_n  = reg_rdata;
                pend_n  = DUAL_RESP;
                state_n = SEND;
            end
            SEND: begin
                if (!tx_busy) begin
                    tx_data_n  = resp;
                    tx_wr_en_n = 1'b1;
                    sw_first_n = 1'b1;
                    state_n    = SEND_WAIT;
                end
            end
            SEND_WAIT: begin
                // tx_busy lags wr_en by one cycle, so the first cycle here says nothing.
                if (!sw_first && !tx_busy) begin
                    if (resp_pend) begin
                        resp_n  = ~resp;
                        pend_n  = 1'b0;
                        state_n = SEND;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        if (in_get && !accept) begin
            if (timer == TMR_LAST) begin
                state_n = IDLE;
            end else begin
                timer_n = timer + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_50m) begin
        if (rst) begin
            state      <= IDLE;
            timer      <= '0;
            rx_rdy_clr <= 1'b0;
            tx_wr_en   <= 1'b0;
            reg_we     <= 1'b0;
            reg_re     <= 1'b0;
            tx_data    <= 8'h00;
            reg_addr   <= 8'h00;
            reg_wdata  <= 8'h00;
            resp_pend  <= 1'b0;
            sw_first   <= 1'b0;
        end else begin
            state      <= state_n;
            timer      <= timer_n;
            rx_rdy_clr <= rx_rdy_clr_n;
            tx_wr_en   <= tx_wr_en_n;
            reg_we     <= reg_we_n;
            reg_re     <= reg_re_n;
            tx_data    <= tx_data_n;
            reg_addr   <= reg_addr_n;
            reg_wdata  <= reg_wdata_n;
            resp_pend  <= pend_n;
            sw_first   <= sw_first_n;
        end
    end

    // Frame bookkeeping is always rewritten before use, so it carries no reset.
    always_ff @(posedge clk_50m) begin
        is_wr   <= is_wr_n;
        resp    <= resp_n;
`ifdef UART_RESP_CHECKSUM_EN
        chk_acc <= chk_acc_n;
        chk_ok  <= chk_ok_n;
`endif
    end

endmodule

// File: tb/tb_uart_reg_responder.sv
// Bench for uart_reg_responder: UART-side and register-slave models, frame-level reference model, random frames.
// Follows UART_RESP_CHECKSUM_EN in the same way as the design.
module tb_uart_reg_responder;
    localparam int         TMO    = 64;
    localparam int         TX_LEN = 8;
    localparam logic [7:0] ACK    = 8'h06;
    localparam logic [7:0] NAK    = 8'h15;

    logic       clk_50m = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_rdy;
    logic       rx_rdy_clr;
    logic [7:0] tx_data;
    logic       tx_wr_en;
    logic       tx_busy;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic       reg_re;
    logic [7:0] reg_rdata;

    uart_reg_responder #(.TIMEOUT_CYC(TMO), .ACK_BYTE(ACK), .NAK_BYTE(NAK)) dut (
        .clk_50m(clk_50m), .rst(rst),
        .rx_data(rx_data), .rx_rdy(rx_rdy), .rx_rdy_clr(rx_rdy_clr),
        .tx_data(tx_data), .tx_wr_en(tx_wr_en), .tx_busy(tx_busy),
        .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we), .reg_re(reg_re),
        .reg_rdata(reg_rdata)
    );

    always #10 clk_50m = ~clk_50m;

    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;
    int unsigned clr_cyc = 0;
    logic [7:0]  tx_q[$];
    int unsigned tx_cyc_q[$];
    logic [7:0]  wr_a_q[$], wr_d_q[$], rd_a_q[$];
    int unsigned wr_cyc_q[$], rd_cyc_q[$];
    logic [7:0]  slave_mem [256];
    bit          mem_ready = 1'b0;
    logic        busy_model = 1'b0;
    int          busy_left = 0;
    logic        force_busy;

    logic [7:0]  mem_model [256];
    logic [7:0]  frame_q[$];
    logic [7:0]  exp_tx[$], exp_wr_a[$], exp_wr_d[$], exp_rd_a[$];
    int          exp_lat;

    function automatic logic [7:0] init_val(input int i);
        return 8'(i * 29 + 7);
    endfunction

    always @(posedge clk_50m) cyc <= cyc + 1;

    // UART transmitter and register slave models, sampled mid-cycle.
    always @(negedge clk_50m) begin
        if (!mem_ready) begin
            for (int i = 0; i < 256; i++) slave_mem[i] = init_val(i);
            mem_ready = 1'b1;
        end
        if (rx_rdy_clr) clr_cyc = cyc;
        if (reg_we) begin
            wr_a_q.push_back(reg_addr);
            wr_d_q.push_back(reg_wdata);
            wr_cyc_q.push_back(cyc);
            slave_mem[reg_addr] = reg_wdata;
        end
        if (reg_re) begin
            rd_a_q.push_back(reg_addr);
            rd_cyc_q.push_back(cyc);
        end
        if (tx_wr_en) begin
            tx_q.push_back(tx_data);
            tx_cyc_q.push_back(cyc);
            busy_model = 1'b1;
            busy_left  = TX_LEN;
        end else if (busy_left > 0) begin
            busy_left--;
            if (busy_left == 0) busy_model = 1'b0;
        end
    end

    assign reg_rdata = slave_mem[reg_addr];
    assign tx_busy   = busy_model | force_busy;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        repeat (gap) @(negedge clk_50m);
        rx_data = b;
        rx_rdy  = 1'b1;
        n = 0;
        do begin
            @(negedge clk_50m);
            n++;
        end while (!rx_rdy_clr && n < 50);
        check($sformatf("accept_%02h", b), rx_rdy_clr, 1'b1);
        // Hold rx_rdy through the clear cycle, as a real receiver would.
        @(negedge clk_50m);
        rx_rdy = 1'b0;
    endtask

    task automatic make_frame(input logic [7:0] c, input logic [7:0] a, input logic [7:0] d, input bit bad);
        logic [7:0] x;
        frame_q.delete();
        frame_q.push_back(c);
        if (c == 8'h57 || c == 8'h52) frame_q.push_back(a);
        if (c == 8'h57) frame_q.push_back(d);
        x = 8'h00;
        foreach (frame_q[i]) x ^= frame_q[i];
        if (bad) x ^= 8'($urandom_range(1, 255));
`ifdef UART_RESP_CHECKSUM_EN
        if (c == 8'h57 || c == 8'h52) frame_q.push_back(x);
`endif
    endtask

    // Frame-level expectation: accesses, response bytes and latency from last accepted byte to first send.
    task automatic model_frame();
        logic [7:0] cmd, r;
        bit         ok;
        exp_tx.delete();
        exp_wr_a.delete();
        exp_wr_d.delete();
        exp_rd_a.delete();
        cmd = frame_q[0];
        ok  = 1'b1;
`ifdef UART_RESP_CHECKSUM_EN
        if (cmd == 8'h57 || cmd == 8'h52) begin
            logic [7:0] c;
            c = 8'h00;
            for (int i = 0; i < frame_q.size() - 1; i++) c ^= frame_q[i];
            ok = (c == frame_q[frame_q.size() - 1]);
        end
`endif
        if (cmd == 8'h57 && ok) begin
            exp_wr_a.push_back(frame_q[1]);
            exp_wr_d.push_back(frame_q[2]);
            mem_model[frame_q[1]] = frame_q[2];
            r = ACK;
            exp_lat = 2;
        end else if (cmd == 8'h52 && ok) begin
            exp_rd_a.push_back(frame_q[1]);
            r = mem_model[frame_q[1]];
            exp_lat = 3;
        end else begin
            r = NAK;
            exp_lat = (cmd == 8'h57 || cmd == 8'h52) ? 2 : 1;
        end
        exp_tx.push_back(r);
`ifdef UART_RESP_CHECKSUM_EN
        exp_tx.push_back(~r);
`endif
    endtask

    task automatic run_frame(input string tag, input int gap_lo, input int gap_hi, input int busy_hold);
        int          tx0, wr0, rd0, n;
        int unsigned rel;
        model_frame();
        tx0 = tx_q.size();
        wr0 = wr_a_q.size();
        rd0 = rd_a_q.size();
        if (busy_hold > 0) force_busy = 1'b1;
        foreach (frame_q[i]) send_byte(frame_q[i], $urandom_range(gap_lo, gap_hi));
        rel = 0;
        if (busy_hold > 0) begin
            repeat (busy_hold) @(negedge clk_50m);
            check($sformatf("%s_tx_while_busy", tag), tx_q.size() - tx0, 0);
            rel = cyc;
            force_busy = 1'b0;
        end
        n = 0;
        while ((tx_q.size() - tx0 < exp_tx.size() || tx_busy) && n < 3000) begin
            @(negedge clk_50m);
            n++;
        end
        repeat (6) @(negedge clk_50m);
        check($sformatf("%s_tx_count", tag), tx_q.size() - tx0, exp_tx.size());
        for (int i = 0; i < exp_tx.size() && tx0 + i < tx_q.size(); i++)
            check($sformatf("%s_tx_byte%0d", tag, i), tx_q[tx0 + i], exp_tx[i]);
        check($sformatf("%s_we_count", tag), wr_a_q.size() - wr0, exp_wr_a.size());
        check($sformatf("%s_re_count", tag), rd_a_q.size() - rd0, exp_rd_a.size());
        if (exp_wr_a.size() == 1 && wr_a_q.size() > wr0) begin
            check($sformatf("%s_wr_addr", tag), wr_a_q[wr0], exp_wr_a[0]);
            check($sformatf("%s_wr_data", tag), wr_d_q[wr0], exp_wr_d[0]);
            check($sformatf("%s_we_lat", tag), wr_cyc_q[wr0] - clr_cyc, 1);
        end
        if (exp_rd_a.size() == 1 && rd_a_q.size() > rd0) begin
            check($sformatf("%s_rd_addr", tag), rd_a_q[rd0], exp_rd_a[0]);
            check($sformatf("%s_re_lat", tag), rd_cyc_q[rd0] - clr_cyc, 1);
        end
        if (tx_q.size() > tx0) begin
            if (busy_hold > 0)
                check($sformatf("%s_tx_after_busy", tag), tx_cyc_q[tx0] - rel, 1);
            else
                check($sformatf("%s_tx_lat", tag), tx_cyc_q[tx0] - clr_cyc, exp_lat);
        end
    endtask

    initial begin
        #(20 * 95000);
        $display("FAIL watchdog cycles=%0d required=finish", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int tx0, wr0;
        rst        = 1'b1;
        rx_rdy     = 1'b0;
        rx_data    = 8'h00;
        force_busy = 1'b0;
        for (int i = 0; i < 256; i++) mem_model[i] = init_val(i);
        repeat (3) @(negedge clk_50m);
        check("rst_rx_rdy_clr", rx_rdy_clr, 0);
        check("rst_tx_wr_en", tx_wr_en, 0);
        check("rst_reg_we", reg_we, 0);
        check("rst_reg_re", reg_re, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_reg_addr", reg_addr, 0);
        check("rst_reg_wdata", reg_wdata, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk_50m);

        make_frame(8'h57, 8'h12, 8'hA5, 1'b0);
        run_frame("write", 0, 3, 0);
        make_frame(8'h57, 8'h34, 8'h5C, 1'b0);
        run_frame("write34", 0, 3, 0);
        make_frame(8'h52, 8'h34, 8'h00, 1'b0);
        run_frame("read", 0, 3, 0);
        make_frame(8'h41, 8'h00, 8'h00, 1'b0);
        run_frame("badcmd", 0, 3, 0);
        make_frame(8'h52, 8'h01, 8'h00, 1'b0);
        run_frame("after_bad", 0, 0, 0);

`ifdef UART_RESP_CHECKSUM_EN
        frame_q = '{8'h57, 8'h12, 8'hA5, 8'hE0};
        run_frame("chk_good", 0, 2, 0);
        frame_q = '{8'h57, 8'h12, 8'hA5, 8'h00};
        run_frame("chk_bad", 0, 2, 0);
`endif

        // Partial frame left hanging must vanish without access or response.
        tx0 = tx_q.size();
        wr0 = wr_a_q.size();
        send_byte(8'h57, 1);
        send_byte(8'h12, 1);
        repeat (TMO + 4) @(negedge clk_50m);
        check("timeout_tx", tx_q.size() - tx0, 0);
        check("timeout_we", wr_a_q.size() - wr0, 0);
        make_frame(8'h52, 8'h07, 8'h00, 1'b0);
        run_frame("after_timeout", 0, 2, 0);

        make_frame(8'h57, 8'h09, 8'h3C, 1'b0);
        run_frame("slow_bytes", TMO - 14, TMO - 9, 0);

        make_frame(8'h57, 8'h0A, 8'hC3, 1'b0);
        run_frame("busy", 0, 2, 500);

        // Reset in the middle of a frame.
        tx0 = tx_q.size();
        wr0 = wr_a_q.size();
        send_byte(8'h57, 1);
        send_byte(8'h12, 1);
        @(negedge clk_50m);
        rst = 1'b1;
        @(negedge clk_50m);
        check("mid_rst_rx_rdy_clr", rx_rdy_clr, 0);
        check("mid_rst_tx_wr_en", tx_wr_en, 0);
        check("mid_rst_reg_we", reg_we, 0);
        check("mid_rst_reg_re", reg_re, 0);
        check("mid_rst_tx_data", tx_data, 0);
        check("mid_rst_reg_addr", reg_addr, 0);
        check("mid_rst_reg_wdata", reg_wdata, 0);
        rst = 1'b0;
        repeat (20) @(negedge clk_50m);
        check("mid_rst_no_tx", tx_q.size() - tx0, 0);
        check("mid_rst_no_we", wr_a_q.size() - wr0, 0);
        make_frame(8'h57, 8'h12, 8'h77, 1'b0);
        run_frame("after_rst", 0, 2, 0);

        for (int t = 0; t < 16; t++) begin
            int         sel;
            logic [7:0] c, a, d;
            sel = $urandom_range(0, 9);
            a   = 8'($urandom_range(0, 15));
            d   = 8'($urandom);
            if (sel < 4) c = 8'h57;
            else if (sel < 8) c = 8'h52;
            else begin
                c = 8'($urandom);
                if (c == 8'h57 || c == 8'h52) c = 8'h00;
            end
            make_frame(c, a, d, ($urandom_range(0, 3) == 0));
            run_frame($sformatf("rnd%0d", t), 0, 4, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
